// File: rtl/sr_pkg.sv
// sr_pkg: shared state encoding, latch codes and helpers for the SR latch driver
package sr_pkg;
  typedef enum logic [1:0] {IDLE, PULSE, GAP, CHECK} state_t;
  localparam logic [1:0] SR_SET  = 2'b01;
  localparam logic [1:0] SR_CLR  = 2'b10;
  localparam logic [1:0] SR_HOLD = 2'b11;
  localparam logic [1:0] SR_BAD  = 2'b00;
  function automatic int max_i(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/sr_latch_driver_if.sv
// sr_latch_driver_if: request handshake and status between control logic and the driver
interface sr_latch_driver_if;
  logic req_valid;
  logic req_val;
  logic req_ready;
  logic busy;
  logic done;
  modport master (output req_valid, req_val, input req_ready, busy, done);
  modport slave (input req_valid, req_val, output req_ready, busy, done);
endinterface

// File: rtl/sr_sat_counter.sv
// sr_sat_counter: saturating counter where an increment beats a coincident clear
module sr_sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (inc) cnt <= clr ? W'(1) : (&cnt ? cnt : cnt + 1'b1);
    else if (clr) cnt <= '0;
endmodule

// File: rtl/sr_latch_driver.sv
// sr_latch_driver: turns level requests into timed, always-legal SR latch set/clear pulses with readback
module sr_latch_driver
  import sr_pkg::*;
#(
  parameter int PULSE_W   = 2,
  parameter int GAP_W     = 1,
  parameter bit SKIP_SAME = 1'b1,
  parameter int ERRW      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  sr_latch_driver_if.slave     bus,
  input  logic                 q_fb,
  input  logic                 err_clr,
  output logic                 s,
  output logic                 r,
  output logic                 en,
  output logic                 err,
  output logic [ERRW-1:0]      err_cnt,
  output logic                 shadow,
  output logic                 shadow_vld
);
  localparam int CW = $clog2(max_i(PULSE_W, GAP_W) + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic cmd, cmd_n, skip, mis;
  assign bus.req_ready = state == IDLE;
  assign bus.busy = state != IDLE;
  assign bus.done = state == CHECK;
  assign mis = state == CHECK && q_fb != cmd;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    cmd_n = cmd;
    skip = SKIP_SAME && shadow_vld && bus.req_val == shadow;
    case (state)
      IDLE: if (bus.req_valid) begin
        cmd_n = bus.req_val;
        cnt_n = '0;
        state_n = skip ? CHECK : PULSE;
      end
      PULSE: begin
        cnt_n = cnt == CW'(PULSE_W - 1) ? '0 : cnt + 1'b1;
        state_n = cnt == CW'(PULSE_W - 1) ? GAP : PULSE;
      end
      GAP: begin
        cnt_n = cnt == CW'(GAP_W - 1) ? '0 : cnt + 1'b1;
        state_n = cnt == CW'(GAP_W - 1) ? CHECK : GAP;
      end
      default: state_n = IDLE;
    endcase
  end
  // s/r/en are registered from the next state so the latch gate never sees a glitch
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      cmd <= 1'b0;
      {s, r} <= SR_HOLD;
      en <= 1'b0;
      err <= 1'b0;
      shadow <= 1'b0;
      shadow_vld <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      cmd <= cmd_n;
      {s, r} <= state_n == PULSE ? (cmd_n ? SR_SET : SR_CLR) : SR_HOLD;
      en <= state_n == PULSE || state_n == GAP;
      err <= mis ? 1'b1 : (err_clr ? 1'b0 : err);
      if (state == CHECK) begin
        shadow <= cmd;
        shadow_vld <= 1'b1;
      end
    end
  sr_sat_counter #(.W(ERRW)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (err_clr),
    .inc (mis),
    .cnt (err_cnt)
  );
  a_sr_legal: assert property (@(posedge clk) disable iff (rst) {s, r} != SR_BAD);
endmodule
